tb_mmio_hub: RTL and testbench

Parametrised simulation MMIO hub on the core's data port, between `riscv_core` and `dp_ram` port B. It decodes a register window and passes every other access through to memory unchanged. Inside the window it provides:
- a buffered console with programmable drain rate,
- a 64-bit machine timer that drives the core interrupt,
- a sticky exit register that tells the bench to stop.

---
 rtl/tb_mmio_hub.sv | 193 +++++++++++++++++++
 tb/tb_tb_mmio_hub.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mmio_hub.sv
// MMIO hub: decodes a 32-byte register window (console FIFO, 64-bit timer, exit) and forwards all other accesses to memory.
// Latency: misses add 0 cycles; register accesses complete one cycle after valid (ACK state), one access every 2 cycles.
// Backpressure: misses follow m_ready_i; a TXDATA write to a full console FIFO stalls until the drain frees a slot.
module tb_mmio_hub #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'h000F_FF00,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    DRAIN_DIV  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [ADDR_WIDTH-1:0] s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [3:0]            s_we_i,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic [3:0]            m_we_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  output logic                  con_valid_o,
  output logic [7:0]            con_data_o,
  output logic                  irq_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_code_o
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int LVLW = PTRW + 1;
  localparam int DIVW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_ACK} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_irq;
  logic                  r_exit_vld;
  logic [31:0]           r_exit_code;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PTRW-1:0]       r_wptr;
  logic [PTRW-1:0]       r_rptr;
  logic [LVLW-1:0]       r_level;
  logic [DIVW-1:0]       r_div;
  logic                  r_con_vld;
  logic [7:0]            r_con_dat;

  logic                  w_hit;
  logic [2:0]            w_off;
  logic                  w_wr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tc;
  logic                  w_pop;
  logic                  w_txwr;
  logic                  w_req;
  logic                  w_do;
  logic                  w_push;
  logic [7:0]            w_push_byte;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_hit   = (s_addr_i[ADDR_WIDTH-1:5] == MMIO_BASE[ADDR_WIDTH-1:5]);
  assign w_off   = s_addr_i[4:2];
  assign w_wr    = |s_we_i;
  assign w_full  = (r_level == LVLW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_tc    = (r_div == DIVW'(DRAIN_DIV - 1));
  assign w_pop   = w_tc & ~w_empty;
  assign w_txwr  = w_wr & (w_off == 3'd0);
  // A request is serviceable in IDLE or STALL; ACK only returns to IDLE.
  assign w_req   = s_valid_i & w_hit & (r_state != S_ACK);
  // A same-cycle pop frees the slot, so a push into a full FIFO may proceed.
  assign w_do    = w_req & ~(w_txwr & w_full & ~w_pop);
  assign w_push  = w_do & w_txwr;

  // Miss path is pure wiring; register window answers from the FSM.
  assign m_valid_o    = s_valid_i & ~w_hit;
  assign m_addr_o     = s_addr_i;
  assign m_wdata_o    = s_wdata_i;
  assign m_we_o       = s_we_i;
  assign s_ready_o    = w_hit ? (r_state == S_ACK) : m_ready_i;
  assign s_rdata_o    = w_hit ? r_rdata : m_rdata_i;
  assign con_valid_o  = r_con_vld;
  assign con_data_o   = r_con_dat;
  assign irq_o        = r_irq;
  assign exit_valid_o = r_exit_vld;
  assign exit_code_o  = r_exit_code;

  // Select the byte on the lowest enabled lane for the console.
  always_comb begin
    w_push_byte = s_wdata_i[7:0];
    if (s_we_i[0])      w_push_byte = s_wdata_i[7:0];
    else if (s_we_i[1]) w_push_byte = s_wdata_i[15:8];
    else if (s_we_i[2]) w_push_byte = s_wdata_i[23:16];
    else if (s_we_i[3]) w_push_byte = s_wdata_i[31:24];
  end

  // Register read mux, sampled on the edge entering ACK.
  always_comb begin
    w_rd = '0;
    case (w_off)
      3'd1:    w_rd = {15'd0, r_irq, 8'(r_level), 6'd0, w_empty, w_full};
      3'd2:    w_rd = r_mtime[31:0];
      3'd3:    w_rd = r_mtime[63:32];
      3'd4:    w_rd = r_mtimecmp[31:0];
      3'd5:    w_rd = r_mtimecmp[63:32];
      3'd6:    w_rd = r_exit_code;
      default: w_rd = '0;
    endcase
  end

  // Access FSM with read capture and register side effects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rdata     <= '0;
      r_mtimecmp  <= '1;
      r_exit_vld  <= 1'b0;
      r_exit_code <= '0;
    end else begin
      case (r_state)
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= w_do ? S_ACK : (w_req ? S_STALL : S_IDLE);
      endcase
      if (w_do) begin
        r_rdata <= w_rd;
        if (w_wr) begin
          case (w_off)
            3'd4: r_mtimecmp[31:0]  <= s_wdata_i;
            3'd5: r_mtimecmp[63:32] <= s_wdata_i;
            3'd6: if (!r_exit_vld) begin
                    r_exit_vld  <= 1'b1;
                    r_exit_code <= s_wdata_i;
                  end
            default: ;
          endcase
        end
      end
    end
  end

  // Free-running timer and registered compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtime <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_mtime <= r_mtime + 64'd1;
      r_irq   <= (r_mtime >= r_mtimecmp);
    end
  end

  // Console storage; contents need no reset since the level gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_byte;
  end

  // Console pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTRW'(1);
      if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVLW'(1);
        2'b01:   r_level <= r_level - LVLW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Drain divider: one character every DRAIN_DIV cycles when available.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_con_vld <= 1'b0;
      r_con_dat <= '0;
    end else begin
      r_div     <= w_tc ? '0 : r_div + DIVW'(1);
      r_con_vld <= w_pop;
      if (w_pop) r_con_dat <= r_mem[r_rptr];
    end
  end

endmodule

// File: tb/tb_tb_mmio_hub.sv
// Directed bench for tb_mmio_hub: instance a (depth 16, drain 4), instance b (depth 4, drain 32).
// Inputs driven 1ns after the rising edge; outputs sampled at the same point or on the falling edge.
// Shared request bus; per-instance valid selects which hub is addressed.
module tb_tb_mmio_hub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_vld_a, s_vld_b;
  logic [31:0] s_addr, s_wdat;
  logic [3:0]  s_we;
  logic        m_rdy;
  logic [31:0] m_rdat;

  logic        s_rdy_a, m_vld_a, con_vld_a, irq_a, exit_vld_a;
  logic [31:0] s_rdat_a, m_addr_a, m_wdat_a, exit_code_a;
  logic [3:0]  m_we_a;
  logic [7:0]  con_dat_a;
  logic        s_rdy_b, m_vld_b, con_vld_b, irq_b, exit_vld_b;
  logic [31:0] s_rdat_b, m_addr_b, m_wdat_b, exit_code_b;
  logic [3:0]  m_we_b;
  logic [7:0]  con_dat_b;

  int          n_chk = 0;
  int          n_pass = 0;
  int          tcyc = 0;
  logic [7:0]  qa[$];
  int          qa_cyc[$];
  logic [7:0]  qb[$];
  logic [31:0] tb_mem [0:63];

  always #5 clk = ~clk;

  tb_mmio_hub #(.FIFO_DEPTH(16), .DRAIN_DIV(4)) u_hub_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_vld_a), .s_ready_o(s_rdy_a), .s_addr_i(s_addr), .s_wdata_i(s_wdat),
    .s_we_i(s_we), .s_rdata_o(s_rdat_a),
    .m_valid_o(m_vld_a), .m_ready_i(m_rdy), .m_addr_o(m_addr_a), .m_wdata_o(m_wdat_a),
    .m_we_o(m_we_a), .m_rdata_i(m_rdat),
    .con_valid_o(con_vld_a), .con_data_o(con_dat_a), .irq_o(irq_a),
    .exit_valid_o(exit_vld_a), .exit_code_o(exit_code_a)
  );

  tb_mmio_hub #(.FIFO_DEPTH(4), .DRAIN_DIV(32)) u_hub_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_vld_b), .s_ready_o(s_rdy_b), .s_addr_i(s_addr), .s_wdata_i(s_wdat),
    .s_we_i(s_we), .s_rdata_o(s_rdat_b),
    .m_valid_o(m_vld_b), .m_ready_i(m_rdy), .m_addr_o(m_addr_b), .m_wdata_o(m_wdat_b),
    .m_we_o(m_we_b), .m_rdata_i(m_rdat),
    .con_valid_o(con_vld_b), .con_data_o(con_dat_b), .irq_o(irq_b),
    .exit_valid_o(exit_vld_b), .exit_code_o(exit_code_b)
  );

  // Word memory behind the miss path of instance a.
  assign m_rdat = tb_mem[m_addr_a[7:2]];
  always @(posedge clk) if (m_vld_a && m_rdy && m_we_a != 4'd0) tb_mem[m_addr_a[7:2]] <= m_wdat_a;

  // Cycles since reset release; equals the expected mtime value.
  always @(posedge clk) tcyc <= rst_n ? tcyc + 1 : 0;

  // Console capture.
  always @(negedge clk) begin
    if (con_vld_a) begin qa.push_back(con_dat_a); qa_cyc.push_back(tcyc); end
    if (con_vld_b) qb.push_back(con_dat_b);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic mmio(input bit sel, input logic [31:0] addr, input logic [31:0] wdat,
                      input logic [3:0] we, output logic [31:0] rdat, output int lat);
    s_addr = addr; s_wdat = wdat; s_we = we;
    if (sel) s_vld_b = 1'b1; else s_vld_a = 1'b1;
    rdat = '0; lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if ((sel ? s_rdy_b : s_rdy_a) === 1'b1) begin
        rdat = sel ? s_rdat_b : s_rdat_a;
        lat  = i;
        break;
      end
    end
    if (lat < 0) chk("mmio_timeout", 64'd0, 64'd1);
    s_vld_a = 1'b0; s_vld_b = 1'b0;
  endtask

  task automatic wait_con_b(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (con_vld_b) begin found = 1; break; end
    end
    if (found == 0) chk(tag, 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, tp, t, nq;
    logic [7:0]  exp_b [6];

    s_vld_a = 1'b0; s_vld_b = 1'b0; s_addr = 32'h000F_FF00; s_wdat = '0; s_we = '0; m_rdy = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",       64'(s_rdy_a), 64'd0);
    chk("rst_rdat",      64'(s_rdat_a), 64'd0);
    chk("rst_mvld",      64'(m_vld_a), 64'd0);
    chk("rst_con_vld",   64'(con_vld_a), 64'd0);
    chk("rst_con_dat",   64'(con_dat_a), 64'd0);
    chk("rst_irq",       64'(irq_a), 64'd0);
    chk("rst_exit_vld",  64'(exit_vld_a), 64'd0);
    chk("rst_exit_code", 64'(exit_code_a), 64'd0);
    rst_n = 1'b1;

    mmio(0, 32'h000F_FF10, 32'd0, 4'h0, rd, lat);
    chk("cmp_lo_rst", 64'(rd), 64'hFFFF_FFFF);
    mmio(0, 32'h000F_FF14, 32'd0, 4'h0, rd, lat);
    chk("cmp_hi_rst", 64'(rd), 64'hFFFF_FFFF);
    mmio(0, 32'h000F_FF04, 32'd0, 4'h0, rd, lat);
    chk("status_rst", 64'(rd), 64'h0000_0002);

    // Timer compare.
    mmio(0, 32'h000F_FF14, 32'd0, 4'hF, rd, lat);
    mmio(0, 32'h000F_FF10, 32'd50, 4'hF, rd, lat);
    chk("irq_pre", 64'(irq_a), 64'd0);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (irq_a) begin t = tcyc; break; end
    end
    chk("irq_rise_cyc", 64'(t), 64'd51);
    mmio(0, 32'h000F_FF04, 32'd0, 4'h0, rd, lat);
    chk("status_irq", 64'(rd), 64'h0001_0002);
    mmio(0, 32'h000F_FF08, 32'd0, 4'h0, rd, lat);
    t = tcyc;
    chk("mtime_lo", 64'(rd), 64'(t - 1));
    mmio(0, 32'h000F_FF0C, 32'd0, 4'h0, rd, lat);
    chk("mtime_hi", 64'(rd), 64'd0);
    mmio(0, 32'h000F_FF10, 32'hFFFF_FFFF, 4'hF, rd, lat);
    chk("irq_hold", 64'(irq_a), 64'd1);
    mmio(0, 32'h000F_FF14, 32'hFFFF_FFFF, 4'hF, rd, lat);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_drop", 64'(irq_a), 64'd0);

    // Exit register.
    chk("exit_vld_pre", 64'(exit_vld_a), 64'd0);
    mmio(0, 32'h000F_FF18, 32'h2A, 4'hF, rd, lat);
    mmio(0, 32'h000F_FF18, 32'h07, 4'hF, rd, lat);
    chk("exit_vld", 64'(exit_vld_a), 64'd1);
    chk("exit_code", 64'(exit_code_a), 64'h2A);
    mmio(0, 32'h000F_FF18, 32'd0, 4'h0, rd, lat);
    chk("exit_read", 64'(rd), 64'h2A);
    mmio(0, 32'h000F_FF1C, 32'd0, 4'h0, rd, lat);
    chk("rsvd_read", 64'(rd), 64'd0);
    mmio(0, 32'h000F_FF00, 32'd0, 4'h0, rd, lat);
    chk("txdata_read", 64'(rd), 64'd0);

    // Hit: memory side idle, ready one cycle after valid.
    @(posedge clk); #1;
    s_addr = 32'h000F_FF04; s_we = 4'h0; s_vld_a = 1'b1;
    #1;
    chk("hit_mvld", 64'(m_vld_a), 64'd0);
    chk("hit_rdy0", 64'(s_rdy_a), 64'd0);
    mmio(0, 32'h000F_FF04, 32'd0, 4'h0, rd, lat);
    chk("hit_lat", 64'(lat), 64'd1);

    // Miss pass-through.
    @(posedge clk); #1;
    s_addr = 32'h0000_0100; s_wdat = 32'hDEAD_BEEF; s_we = 4'hF; s_vld_a = 1'b1; m_rdy = 1'b0;
    #1;
    chk("miss_mvld", 64'(m_vld_a), 64'd1);
    chk("miss_addr", 64'(m_addr_a), 64'h100);
    chk("miss_wdat", 64'(m_wdat_a), 64'hDEAD_BEEF);
    chk("miss_we",   64'(m_we_a), 64'hF);
    chk("miss_rdy0", 64'(s_rdy_a), 64'd0);
    chk("b_pass",    {m_addr_b, m_wdat_b}, {32'h0000_0100, 32'hDEAD_BEEF});
    chk("b_we",      64'(m_we_b), 64'hF);
    chk("b_mvld",    64'(m_vld_b), 64'd0);
    m_rdy = 1'b1;
    #1;
    chk("miss_rdy1", 64'(s_rdy_a), 64'd1);
    @(posedge clk); #1;
    s_vld_a = 1'b0; s_we = 4'h0;
    #1;
    s_vld_a = 1'b1;
    #1;
    chk("miss_rdat", 64'(s_rdat_a), 64'hDEAD_BEEF);
    chk("miss_rd_rdy", 64'(s_rdy_a), 64'd1);
    s_vld_a = 1'b0; m_rdy = 1'b0;

    // Console ordering on instance a.
    @(posedge clk); #1;
    mmio(0, 32'h000F_FF00, 32'h4800_0000, 4'b1000, rd, lat);
    tp = tcyc;
    mmio(0, 32'h000F_FF00, 32'h6900_0000, 4'b1000, rd, lat);
    repeat (20) @(posedge clk);
    #1;
    chk("con_count", 64'(qa.size()), 64'd2);
    if (qa.size() == 2) begin
      chk("con_dat0", 64'(qa[0]), 64'h48);
      chk("con_dat1", 64'(qa[1]), 64'h69);
      chk("con_gap", 64'(qa_cyc[1] - qa_cyc[0]), 64'd4);
      chk("con_lat", 64'((qa_cyc[0] - tp) <= 4), 64'd1);
    end

    // Full-FIFO stall on instance b, aligned to a drain pop.
    mmio(1, 32'h000F_FF00, 32'h5A00_0000, 4'b1000, rd, lat);
    wait_con_b("align_timeout");
    for (int i = 0; i < 4; i++) mmio(1, 32'h000F_FF00, 32'h4100_0000 + (32'(i) << 24), 4'b1000, rd, lat);
    mmio(1, 32'h000F_FF04, 32'd0, 4'h0, rd, lat);
    chk("status_full", 64'(rd), 64'h0000_0401);
    chk("no_pop_yet", 64'(qb.size()), 64'd1);
    mmio(1, 32'h000F_FF00, 32'h4500_0000, 4'b1000, rd, lat);
    chk("stall_lat", 64'(lat), 64'd23);
    chk("stall_release_pop", 64'(con_vld_b), 64'd1);
    chk("stall_release_dat", 64'(con_dat_b), 64'h41);
    repeat (150) @(posedge clk);
    #1;
    exp_b = '{8'h5A, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk("drain_count", 64'(qb.size()), 64'd6);
    if (qb.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("drain_%0d", i), 64'(qb[i]), 64'(exp_b[i]));

    // Reset while stalled with a full FIFO.
    mmio(1, 32'h000F_FF00, 32'h5A00_0000, 4'b1000, rd, lat);
    wait_con_b("align2_timeout");
    for (int i = 0; i < 4; i++) mmio(1, 32'h000F_FF00, 32'h6100_0000 + (32'(i) << 24), 4'b1000, rd, lat);
    s_addr = 32'h000F_FF00; s_wdat = 32'h6500_0000; s_we = 4'b1000; s_vld_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_hold", 64'(s_rdy_b), 64'd0);
    rst_n = 1'b0; s_vld_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_con_vld_b", 64'(con_vld_b), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nq = qb.size();
    repeat (40) @(posedge clk);
    #1;
    chk("no_con_after_rst", 64'(qb.size()), 64'(nq));
    mmio(1, 32'h000F_FF04, 32'd0, 4'h0, rd, lat);
    chk("status_after_rst", 64'(rd), 64'h0000_0002);
    chk("exit_cleared_a", 64'(exit_vld_a), 64'd0);
    chk("b_exit", {31'd0, exit_vld_b, exit_code_b}, 64'd0);
    chk("b_irq", 64'(irq_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
